// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and divider helper for uart_core
package uart_pkg;

   typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_e;

   // Rounded clocks per oversample tick, never below one.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      int d;
      d = (clk_hz + (baud * os) / 2) / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - host handshake and serial pin bundle for uart_core
interface uart_if #(parameter int DATA_BITS = 8);
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 txd;
   logic                 rxd;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_parity_err;
   logic                 rx_overrun;
   logic                 rx_overrun_clr;

   modport slave (
      input  tx_valid, tx_data, rxd, rx_ready, rx_overrun_clr,
      output tx_ready, txd, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun
   );

   modport master (
      output tx_valid, tx_data, rxd, rx_ready, rx_overrun_clr,
      input  tx_ready, txd, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun
   );
endinterface

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - free-running oversample tick, one pulse every DIV clocks
module uart_tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == '0) begin
         r_cnt  <= CW'(DIV - 1);
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt - 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;
endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART with RX holding register; parity via UART_PARITY_EN
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 6250000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0
) (
   input  logic  clk,
   input  logic  rst_n,
   uart_if.slave bus
);
   localparam int             DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int             OSW     = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]     DB_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]     SB_LAST = 4'(STOP_BITS - 1);

   if ((OVERSAMPLE != 8 && OVERSAMPLE != 16) || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_bad_cfg
      $error("uart_core: unsupported frame configuration");
   end

`ifdef UART_PARITY_EN
   localparam logic PAR_INV = (PARITY == int'(PAR_ODD));
`endif

   logic w_tick;

   uart_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(w_tick));

   tx_state_e            r_tx_state;
   logic [OSW-1:0]       r_tx_os;
   logic [3:0]           r_tx_bit;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_txd;
   logic                 r_tx_ready;
`ifdef UART_PARITY_EN
   logic                 r_tx_par;
`endif

   // OVERSAMPLE is a power of two, so the os counters wrap to zero on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_os    <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
         r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
         r_tx_par   <= 1'b0;
`endif
      end else if (r_tx_state == TX_IDLE) begin
         if (!r_tx_ready) begin
            if (w_tick) begin
               r_txd      <= 1'b0;
               r_tx_os    <= '0;
               r_tx_state <= TX_START;
            end
         end else if (bus.tx_valid) begin
            r_tx_shift <= bus.tx_data;
            r_tx_ready <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= (^bus.tx_data) ^ PAR_INV;
`endif
         end
      end else if (w_tick) begin
         r_tx_os <= r_tx_os + 1'b1;
         if (r_tx_os == OS_LAST) begin
            if (r_tx_state == TX_START) begin
               r_txd      <= r_tx_shift[0];
               r_tx_bit   <= '0;
               r_tx_state <= TX_DATA;
            end else if (r_tx_state == TX_DATA) begin
               r_tx_shift <= r_tx_shift >> 1;
               if (r_tx_bit == DB_LAST) begin
                  r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
                  r_txd      <= r_tx_par;
                  r_tx_state <= TX_PARITY;
`else
                  r_txd      <= 1'b1;
                  r_tx_state <= TX_STOP;
`endif
               end else begin
                  r_txd    <= r_tx_shift[1];
                  r_tx_bit <= r_tx_bit + 1'b1;
               end
`ifdef UART_PARITY_EN
            end else if (r_tx_state == TX_PARITY) begin
               r_txd      <= 1'b1;
               r_tx_state <= TX_STOP;
`endif
            end else if (r_tx_bit == SB_LAST) begin
               r_tx_state <= TX_IDLE;
               r_tx_ready <= 1'b1;
            end else begin
               r_tx_bit <= r_tx_bit + 1'b1;
            end
         end
      end
   end

   assign bus.txd      = r_txd;
   assign bus.tx_ready = r_tx_ready;

   rx_state_e            r_rx_state;
   logic [1:0]           r_sync;
   logic [2:0]           r_samp;
   logic                 r_rx_armed;
   logic [OSW-1:0]       r_rx_os;
   logic [3:0]           r_rx_bit;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic                 r_rx_stop;
   logic                 r_rx_done;
   logic                 r_rx_valid;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_ferr;
   logic                 r_rx_ovr;
`ifdef UART_PARITY_EN
   logic                 r_rx_par;
   logic                 r_rx_perr;
`endif
   logic                 w_filt;
   logic                 w_pop;
   logic                 w_load;

   assign w_filt = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
   assign w_pop  = r_rx_valid & bus.rx_ready;
   assign w_load = r_rx_done & (~r_rx_valid | w_pop);

   // After a frame the line must read high for a tick before a new start is
   // accepted, so a held break yields a single framing error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_state <= RX_IDLE;
         r_sync     <= 2'b11;
         r_samp     <= 3'b111;
         r_rx_armed <= 1'b0;
         r_rx_os    <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_stop  <= 1'b1;
         r_rx_done  <= 1'b0;
`ifdef UART_PARITY_EN
         r_rx_par   <= 1'b0;
`endif
      end else begin
         r_sync    <= {r_sync[0], bus.rxd};
         r_rx_done <= 1'b0;
         if (w_tick) begin
            r_samp <= {r_samp[1:0], r_sync[1]};
            if (r_rx_state == RX_IDLE) begin
               if (!r_rx_armed) begin
                  r_rx_armed <= w_filt;
               end else if (!w_filt) begin
                  r_rx_os    <= '0;
                  r_rx_state <= RX_START;
               end
            end else begin
               r_rx_os <= r_rx_os + 1'b1;
               if (r_rx_state == RX_START) begin
                  if (r_rx_os == OS_MID) begin
                     r_rx_os    <= '0;
                     r_rx_bit   <= '0;
                     r_rx_state <= w_filt ? RX_IDLE : RX_DATA;
                  end
               end else if (r_rx_os == OS_LAST) begin
                  if (r_rx_state == RX_DATA) begin
                     r_rx_shift <= {w_filt, r_rx_shift[DATA_BITS-1:1]};
                     r_rx_bit   <= r_rx_bit + 1'b1;
                     if (r_rx_bit == DB_LAST) begin
`ifdef UART_PARITY_EN
                        r_rx_state <= RX_PARITY;
`else
                        r_rx_state <= RX_STOP;
`endif
                     end
`ifdef UART_PARITY_EN
                  end else if (r_rx_state == RX_PARITY) begin
                     r_rx_par   <= w_filt;
                     r_rx_state <= RX_STOP;
`endif
                  end else begin
                     r_rx_stop  <= w_filt;
                     r_rx_done  <= 1'b1;
                     r_rx_armed <= 1'b0;
                     r_rx_state <= RX_IDLE;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_ferr  <= 1'b0;
         r_rx_ovr   <= 1'b0;
      end else begin
         if (w_load) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_shift;
            r_rx_ferr  <= ~r_rx_stop;
         end else if (w_pop) begin
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
         end
         if (bus.rx_overrun_clr)
            r_rx_ovr <= 1'b0;
         if (r_rx_done && !w_load)
            r_rx_ovr <= 1'b1;
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rx_perr <= 1'b0;
      else if (w_load)
         r_rx_perr <= r_rx_par ^ (^r_rx_shift) ^ PAR_INV;
      else if (w_pop)
         r_rx_perr <= 1'b0;
   end
   assign bus.rx_parity_err = r_rx_perr;
`else
   assign bus.rx_parity_err = 1'b0;
`endif

   assign bus.rx_valid     = r_rx_valid;
   assign bus.rx_data      = r_rx_data;
   assign bus.rx_frame_err = r_rx_ferr;
   assign bus.rx_overrun   = r_rx_ovr;
endmodule
